// File: rtl/rr_fifo_switch_pkg.sv
// Shared types and helpers for the round-robin FIFO switch.
// Holds the FSM state encoding, channel-index width and destination-field extract.
package rr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The destination is the top ch_w bits of a word that is data_w bits wide.
  function automatic logic [31:0] dest_of(input logic [63:0] word, input int data_w,
                                          input int ch_w);
    return 32'((word >> (data_w - ch_w)) & ((64'd1 << ch_w) - 64'd1));
  endfunction

endpackage

// File: rtl/rr_rot_pick.sv
// Rotating priority encoder: returns the first set request strictly after ptr,
// wrapping modulo N, with ptr itself considered last.
module rr_rot_pick
  import rr_pkg::*;
#(
  parameter int N    = 4,
  parameter int CH_W = ch_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic            found,
  output logic [CH_W-1:0] idx
);

  logic [CH_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 1; k <= N; k++) begin
      cand = ptr + CH_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_fifo_switch.sv
// Round-robin switch from N first-word-fall-through input FIFOs to N output FIFOs,
// routing each word by its destination field with a one-cycle push register.
module rr_fifo_switch
  import rr_pkg::*;
#(
  parameter int  N      = 4,
  parameter int  DATA_W = 10,
  parameter int  BURST  = 1,
  localparam int CH_W   = ch_width(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [N-1:0]        empty_in,
  input  logic [N*DATA_W-1:0] data_in,
  output logic [N-1:0]        pop_in,
  input  logic [N-1:0]        almost_full_out,
  output logic [N-1:0]        push_out,
  output logic [N*DATA_W-1:0] data_out,
  output logic                grant_valid,
  output logic [CH_W-1:0]     grant_id
);

  localparam int BURST_W = (BURST > 1) ? $clog2(BURST + 1) : 1;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d, last_id_q, pick_idx;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [N-1:0]        elig, push_q, push_d;
  logic [DATA_W-1:0]   word_q, sel_word;
  logic [CH_W-1:0]     dest [N];
  logic                pick_found, grant, keep;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      dest[i] = CH_W'(dest_of(64'(data_in[i*DATA_W +: DATA_W]), DATA_W, CH_W));
      elig[i] = enable & ~empty_in[i] & ~almost_full_out[dest[i]];
    end
  end

  rr_rot_pick #(
    .N    (N),
    .CH_W (CH_W)
  ) u_pick (
    .req   (elig),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Stay on the current input while its burst allowance lasts, otherwise rotate
  // in the same cycle so a switch never costs a bubble.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    grant   = 1'b0;
    keep    = (state_q == GRANT) && elig[ptr_q] && (burst_q < BURST_W'(BURST));
    if (keep) begin
      grant   = 1'b1;
      burst_d = burst_q + BURST_W'(1);
    end else if (pick_found) begin
      grant   = 1'b1;
      ptr_d   = pick_idx;
      burst_d = BURST_W'(1);
      state_d = GRANT;
    end else begin
      state_d = IDLE;
      burst_d = '0;
    end
    if (!reset) begin
      grant = 1'b0;
    end
  end

  always_comb begin
    pop_in   = '0;
    push_d   = '0;
    sel_word = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr_d == CH_W'(i)) begin
        sel_word = data_in[i*DATA_W +: DATA_W];
      end
    end
    if (grant) begin
      pop_in[ptr_d]       = 1'b1;
      push_d[dest[ptr_d]] = 1'b1;
    end
  end

  assign grant_valid = grant;
  assign grant_id    = grant ? ptr_d : last_id_q;

  // ptr resets to N-1 so the first scan after reset lands on channel 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= CH_W'(N - 1);
      burst_q   <= '0;
      last_id_q <= '0;
      push_q    <= '0;
      word_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      push_q  <= push_d;
      if (grant) begin
        last_id_q <= ptr_d;
        word_q    <= sel_word;
      end
    end
  end

  assign push_out = push_q;
  assign data_out = {N{word_q}};

endmodule

// File: tb/tb_rr_fifo_switch.sv
// Scoreboard bench for rr_fifo_switch: BURST=1 and BURST=3 instances share the
// input FIFO model; expected grants and pushes are queued by the directed tests.
module tb_rr_fifo_switch;
  import rr_pkg::*;

  localparam int N  = 4;
  localparam int DW = 10;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b1;
  logic            sel = 1'b0;
  logic [N-1:0]    empty_in;
  logic [N-1:0]    almost_full_out = '0;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    pop_a, pop_b, push_a, push_b, pop_s, push_s, pop_cap;
  logic [N*DW-1:0] dout_a, dout_b, dout_s;
  logic            gv_a, gv_b, gv_s;
  logic [CW-1:0]   gid_a, gid_b, gid_s;

  logic [DW-1:0]   mem [N][16];
  int              head [N];
  int              tail [N];
  int              total = 0;
  int              bad = 0;
  int              exp_grant [$];
  logic [N+DW-1:0] exp_push [$];
  int              mon_g;
  logic [N+DW-1:0] mon_p;

  always #5 clk = ~clk;

  rr_fifo_switch #(.N(N), .DATA_W(DW), .BURST(1)) dut_b1 (
    .clk(clk), .reset(reset), .enable(enable), .empty_in(empty_in), .data_in(data_in),
    .pop_in(pop_a), .almost_full_out(almost_full_out), .push_out(push_a),
    .data_out(dout_a), .grant_valid(gv_a), .grant_id(gid_a)
  );

  rr_fifo_switch #(.N(N), .DATA_W(DW), .BURST(3)) dut_b3 (
    .clk(clk), .reset(reset), .enable(enable), .empty_in(empty_in), .data_in(data_in),
    .pop_in(pop_b), .almost_full_out(almost_full_out), .push_out(push_b),
    .data_out(dout_b), .grant_valid(gv_b), .grant_id(gid_b)
  );

  assign pop_s  = sel ? pop_b  : pop_a;
  assign push_s = sel ? push_b : push_a;
  assign dout_s = sel ? dout_b : dout_a;
  assign gv_s   = sel ? gv_b   : gv_a;
  assign gid_s  = sel ? gid_b  : gid_a;

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_inputs();
    for (int i = 0; i < N; i++) begin
      empty_in[i]           = (head[i] == tail[i]);
      data_in[i*DW +: DW]   = mem[i][head[i] & 15];
    end
  endtask

  task automatic apply_stimulus(input int ch, input logic [DW-1:0] w, input bit expect_it);
    mem[ch][tail[ch] & 15] = w;
    tail[ch]++;
    if (expect_it) begin
      exp_grant.push_back(ch);
      exp_push.push_back({N'(1) << w[DW-1 -: CW], w});
    end
    update_inputs();
  endtask

  task automatic start_test(input logic use_b3);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sel = use_b3;
    enable = 1'b1;
    almost_full_out = '0;
    exp_grant.delete();
    exp_push.delete();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    update_inputs();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: grants must appear on n consecutive cycles, the last push one later.
  task automatic wait_drain(input int n);
    repeat (n) @(negedge clk);
    #1;
    check_output("grant_timing", 64'(exp_grant.size()), 64'd0);
    @(negedge clk);
    #1;
    check_output("push_timing", 64'(exp_push.size()), 64'd0);
  endtask

  // Input FIFO model: pops observed in a cycle take effect just after its closing edge.
  always @(negedge clk) begin
    pop_cap = pop_s;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pop_cap[i]) begin
        check_output("pop_not_empty", 64'(head[i] != tail[i]), 64'd1);
        if (head[i] != tail[i]) head[i]++;
      end
    end
    update_inputs();
  end

  always @(negedge clk) begin
    if (gv_s) begin
      if (exp_grant.size() == 0) begin
        check_output("grant_unexpected", 64'(gid_s), 64'hFFFF);
      end else begin
        mon_g = exp_grant.pop_front();
        check_output("grant_id", 64'(gid_s), 64'(mon_g));
        check_output("pop_in", 64'(pop_s), 64'd1 << mon_g);
      end
    end
    if (push_s != '0) begin
      if (exp_push.size() == 0) begin
        check_output("push_unexpected", 64'(push_s), 64'd0);
      end else begin
        mon_p = exp_push.pop_front();
        check_output("push_out", 64'(push_s), 64'(mon_p[N+DW-1:DW]));
        check_output("data_out", 64'(dout_s), 64'({N{mon_p[DW-1:0]}}));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    update_inputs();

    // Reset with full inputs, then BURST=1 rotation over four distinct destinations.
    start_test(1'b0);
    for (int r = 0; r < 2; r++) begin
      apply_stimulus(0, (r == 0) ? 10'h0A1 : 10'h0A2, 1'b1);
      apply_stimulus(1, (r == 0) ? 10'h1B1 : 10'h1B2, 1'b1);
      apply_stimulus(2, (r == 0) ? 10'h2C1 : 10'h2C2, 1'b1);
      apply_stimulus(3, (r == 0) ? 10'h3D1 : 10'h3D2, 1'b1);
    end
    @(negedge clk);
    #1;
    check_output("reset_pop", 64'(pop_s), 64'd0);
    check_output("reset_push", 64'(push_s), 64'd0);
    check_output("reset_data", 64'(dout_s), 64'd0);
    check_output("reset_gv", 64'(gv_s), 64'd0);
    check_output("reset_gid", 64'(gid_s), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_drain(8);

    // BURST=3: 1,1,1,2,2,2,1.
    start_test(1'b1);
    apply_stimulus(1, 10'h011, 1'b1);
    apply_stimulus(1, 10'h012, 1'b1);
    apply_stimulus(1, 10'h013, 1'b1);
    apply_stimulus(2, 10'h321, 1'b1);
    apply_stimulus(2, 10'h322, 1'b1);
    apply_stimulus(2, 10'h323, 1'b1);
    apply_stimulus(1, 10'h014, 1'b1);
    reset = 1'b1;
    wait_drain(7);

    // BURST=3, input 1 runs dry after two words.
    start_test(1'b1);
    apply_stimulus(1, 10'h041, 1'b1);
    apply_stimulus(1, 10'h042, 1'b1);
    apply_stimulus(2, 10'h351, 1'b1);
    apply_stimulus(2, 10'h352, 1'b1);
    apply_stimulus(2, 10'h353, 1'b1);
    reset = 1'b1;
    wait_drain(5);

    // Almost-full destination 2 blocks input 0 until it clears.
    start_test(1'b0);
    almost_full_out = 4'b0100;
    apply_stimulus(0, 10'h2A5, 1'b0);
    apply_stimulus(1, 10'h055, 1'b1);
    apply_stimulus(3, 10'h3C3, 1'b1);
    reset = 1'b1;
    wait_drain(2);
    @(negedge clk);
    #1;
    check_output("af_skip_gv", 64'(gv_s), 64'd0);
    @(posedge clk);
    #1;
    exp_grant.push_back(0);
    exp_push.push_back({4'b0100, 10'h2A5});
    almost_full_out = '0;
    wait_drain(1);

    // Inputs 0 and 3 contend for destination 1.
    start_test(1'b0);
    apply_stimulus(0, 10'h101, 1'b1);
    apply_stimulus(3, 10'h1F1, 1'b1);
    apply_stimulus(0, 10'h102, 1'b1);
    apply_stimulus(3, 10'h1F2, 1'b1);
    apply_stimulus(0, 10'h103, 1'b1);
    apply_stimulus(3, 10'h1F3, 1'b1);
    reset = 1'b1;
    wait_drain(6);

    // Reset during the in-flight push, then the scan restarts at channel 0.
    start_test(1'b0);
    apply_stimulus(0, 10'h0E7, 1'b0);
    exp_grant.push_back(0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("push_before_reset", 64'(push_s), 64'h1);
    reset = 1'b0;
    #1;
    check_output("push_on_reset", 64'(push_s), 64'd0);
    check_output("data_on_reset", 64'(dout_s), 64'd0);
    check_output("grant_consumed", 64'(exp_grant.size()), 64'd0);
    @(posedge clk);
    #1;
    apply_stimulus(3, 10'h3E9, 1'b0);
    apply_stimulus(0, 10'h0E8, 1'b1);
    exp_grant.push_back(3);
    exp_push.push_back({4'b1000, 10'h3E9});
    reset = 1'b1;
    wait_drain(2);

    // Enable drop: in-flight push completes, no new pops until re-enabled.
    start_test(1'b0);
    apply_stimulus(2, 10'h0B1, 1'b1);
    apply_stimulus(2, 10'h0B2, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check_output("enable_low_gv", 64'(gv_s), 64'd0);
    end
    check_output("enable_low_push_done", 64'(exp_push.size()), 64'd0);
    @(posedge clk);
    #1;
    exp_grant.push_back(2);
    exp_push.push_back({4'b0001, 10'h0B2});
    enable = 1'b1;
    wait_drain(1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
